// File: rtl/pi_inv_seq.sv
// Bit-serial inverse Spongent pLayer: out[4k mod (B-1)] = in[k], bit B-1 fixed, one bit per clock.
// Optional idx_dbg port enabled by defining PI_INV_IDX_DBG_EN.
module pi_inv_seq #(
    parameter int B    = 88,
    parameter int IDXW = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [B-1:0]    in_state,
    output logic            busy,
    output logic            done,
    output logic [B-1:0]    out_state
`ifdef PI_INV_IDX_DBG_EN
    ,
    output logic [IDXW-1:0] idx_dbg
`endif
);

    // Handshake: start is only looked at in IDLE (no queueing); done pulses for one
    // cycle in the first IDLE cycle after an operation, and out_state is valid from
    // then until the next accepted start.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDXW-1:0] K_LAST = IDXW'(B - 1);
    localparam logic [IDXW-1:0] K_PRE  = IDXW'(B - 2);
    localparam logic [IDXW:0]   MOD    = (IDXW + 1)'(B - 1);

    logic [1:0]      state;
    logic [IDXW-1:0] k;
    logic [IDXW-1:0] idx;
    logic [B-1:0]    latch;
    logic [IDXW:0]   t;
    logic [IDXW-1:0] idx_next;

    // Incremental 4k mod (B-1); t stays below 2*(B-1) so one subtract is enough.
    // The subtract wraps modulo 2^IDXW, which is exact because its true result fits.
    always_comb begin
        t        = {1'b0, idx} + (IDXW + 1)'(4);
        idx_next = t[IDXW-1:0];
        if (t >= MOD) begin
            idx_next = t[IDXW-1:0] - K_LAST;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            k         <= '0;
            idx       <= '0;
            latch     <= '0;
            out_state <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        latch     <= in_state;
                        out_state <= '0;
                        k         <= '0;
                        idx       <= '0;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    // latch shifts right so latch[0] always holds original bit k
                    out_state <= out_state | ({{(B-1){1'b0}}, latch[0]} << idx);
                    latch     <= latch >> 1;
                    if (k == K_LAST) begin
                        state <= S_DONE;
                    end else begin
                        k <= k + IDXW'(1);
                    end
                    idx <= (k == K_PRE) ? K_LAST : idx_next;
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);

`ifdef PI_INV_IDX_DBG_EN
    assign idx_dbg = (state == S_RUN) ? idx : '0;
`endif

endmodule
